adder_arbiter: RTL

Shares one 4-bit ripple-carry nibble adder between two requesters and sequences multi-nibble additions over it. Each accepted request adds two `4*NIBBLES`-bit operands one nibble per cycle, LSB nibble first, with the carry held in a register between nibbles. Grants are round-robin. The result is returned on a single valid/ready response channel tagged with the requester ID. The block sits between the operand sources and downstream consumers, in place of a full-width adder.

---
 rtl/adder_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 4-bit ripple nibble adder between two requesters.
// Optional subtract support (A + ~B, carry-in 1) is enabled by defining ADDER_ARB_SUB_EN.

module adder_arbiter_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end
endmodule

module adder_arbiter #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [4*NIBBLES-1:0]   req0_a,
  input  logic [4*NIBBLES-1:0]   req0_b,
`ifdef ADDER_ARB_SUB_EN
  input  logic                   req0_sub,
  input  logic                   req1_sub,
`endif
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [4*NIBBLES-1:0]   req1_a,
  input  logic [4*NIBBLES-1:0]   req1_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [4*NIBBLES-1:0]   rsp_sum,
  output logic                   rsp_cout,
  output logic                   rsp_id
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic             ptr;
  logic             carry_reg;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     acc;
  logic             id_reg;

  logic             grant_any;
  logic             grant_id;
  logic             sel_sub;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;

  logic [3:0]       nib_s;
  logic [4:0]       nib_c;
  logic [W+3:0]     acc_cat;
  logic [W-1:0]     acc_next;

  // Arbitration: a lone valid wins, otherwise ptr picks the winner.
  always_comb begin
    grant_any  = ena & (state == S_IDLE) & (req0_valid | req1_valid);
    grant_id   = (req0_valid & req1_valid) ? ptr : req1_valid;
    req0_ready = grant_any & ~grant_id;
    req1_ready = grant_any & grant_id;
    sel_a      = grant_id ? req1_a : req0_a;
    sel_b      = grant_id ? req1_b : req0_b;
`ifdef ADDER_ARB_SUB_EN
    sel_sub    = grant_id ? req1_sub : req0_sub;
`else
    sel_sub    = 1'b0;
`endif
  end

  assign nib_c[0] = carry_reg;

  for (genvar g = 0; g < 4; g++) begin : g_fa
    adder_arbiter_fa u_fa (
      .a  (a_reg[g]),
      .b  (b_reg[g]),
      .ci (nib_c[g]),
      .s  (nib_s[g]),
      .co (nib_c[g+1])
    );
  end

  // Operands shift down one nibble per step; sum nibbles shift in from the top.
  always_comb begin
    acc_cat  = {nib_s, acc};
    acc_next = acc_cat[W+3:4];
  end

  always_comb begin
    rsp_valid = ena & (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= 1'b0;
      carry_reg <= 1'b0;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      id_reg    <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= 1'b0;
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            a_reg     <= sel_a;
            b_reg     <= sel_b ^ {W{sel_sub}};
            carry_reg <= sel_sub;
            idx       <= '0;
            id_reg    <= grant_id;
            state     <= S_ADD;
          end
        end
        S_ADD: begin
          a_reg     <= a_reg >> 4;
          b_reg     <= b_reg >> 4;
          acc       <= acc_next;
          carry_reg <= nib_c[4];
          idx       <= idx + 1'b1;
          if (idx == LAST) begin
            rsp_sum  <= acc_next;
            rsp_cout <= nib_c[4];
            rsp_id   <= id_reg;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            ptr   <= ~id_reg;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
